// File: rtl/text_buffer_ctrl.sv
// text_buffer_ctrl: writable 16x16 character buffer for the VGA text box.
// Two game-logic requesters write single cells through a req/ack handshake
// under round-robin arbitration. A clear sequencer refills the whole screen
// after reset or on command. The renderer reads through a registered port
// with one cycle of latency.
//
// Handshake: a requester raises wr_req[i] with wr_addr/wr_code and holds all
// three stable until wr_ack[i] is seen high. The write lands on the clock edge
// that ends the grant cycle, and wr_ack[i] is high for exactly the following
// cycle. In that ack cycle requester i is not eligible, so a held request is
// never written twice. The requester then either drops wr_req[i] or presents
// new data. Dropping wr_req[i] before the ack withdraws the request and no
// write occurs.

package vga_pkg;
  localparam logic [6:0] Spc = 7'h20;
endpackage

module text_buffer_ctrl #(
  parameter logic [6:0] FILL_CODE   = vga_pkg::Spc,
  parameter logic [6:0] BORDER_CODE = 7'h0e
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_req,
  output logic       busy,
  input  logic [1:0] wr_req,
  input  logic [7:0] wr_addr0,
  input  logic [7:0] wr_addr1,
  input  logic [6:0] wr_code0,
  input  logic [6:0] wr_code1,
  output logic [1:0] wr_ack,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e     state_q;
  logic [7:0] clr_cnt_q;
  logic       last_grant_q;   // index of the requester granted most recently
  logic [1:0] wr_ack_q;
  logic       busy_q;
  logic [6:0] char_code_q;
  logic [6:0] mem_q [256];

  logic [1:0] eligible;
  logic [1:0] grant_d;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [6:0] mem_wdata;

  assign busy      = busy_q;
  assign wr_ack    = wr_ack_q;
  assign char_code = char_code_q;

  // Round-robin grant: only in IDLE, and a clear request takes the cycle.
  always_comb begin
    eligible = wr_req & ~wr_ack_q;
    grant_d  = 2'b00;
    if (state_q == ST_IDLE && !clr_req) begin
      case (eligible)
        2'b01:   grant_d = 2'b01;
        2'b10:   grant_d = 2'b10;
        2'b11:   grant_d = last_grant_q ? 2'b01 : 2'b10;
        default: grant_d = 2'b00;
      endcase
    end
  end

  // Single memory write port, shared by the clear sweep and the granted requester.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_cnt_q;
    mem_wdata = FILL_CODE;
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = (clr_cnt_q[7:4] == 4'hF) ? BORDER_CODE : FILL_CODE;
      end else if (grant_d[0]) begin
        mem_we    = 1'b1;
        mem_waddr = wr_addr0;
        mem_wdata = wr_code0;
      end else if (grant_d[1]) begin
        mem_we    = 1'b1;
        mem_waddr = wr_addr1;
        mem_wdata = wr_code1;
      end
    end
  end

  // Control FSM: clear sweep, idle arbitration, registered busy/ack outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= 8'd0;
      last_grant_q <= 1'b1;
      wr_ack_q     <= 2'b00;
      busy_q       <= 1'b1;
    end else begin
      wr_ack_q <= grant_d;
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 8'd1;
          if (clr_cnt_q == 8'hFF) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (clr_req) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= 8'd0;
            busy_q    <= 1'b1;
          end else if (grant_d[0]) begin
            last_grant_q <= 1'b0;
          end else if (grant_d[1]) begin
            last_grant_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_CLEAR;
          clr_cnt_q <= 8'd0;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  // Character storage; contents are initialised by the clear sweep, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Registered renderer read; a same-edge write to the same cell returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      char_code_q <= 7'h00;
    end else begin
      char_code_q <= mem_q[char_xy];
    end
  end

endmodule
